// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data memory with a lower-priority host access port
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemtoRegM,
    input  logic [31:0]   ALUResult,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_ack,
    output logic          addr_err,
    output logic [15:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t state;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] cpu_idx;
    logic          addr_bad;
    logic          cpu_idle;
    logic          cpu_wr_ok;
    logic          host_exec;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    // CPU address decode: word index plus misalignment / out-of-range detection
    always_comb begin
        cpu_idx   = ALUResult[AW+1:2];
        addr_bad  = (ALUResult[1:0] != 2'b00) || ((ALUResult >> (AW + 2)) != 32'd0);
        cpu_idle  = !MemWrite && !MemtoRegM;
        cpu_wr_ok = MemWrite && !addr_bad;
        // The host only executes on a cycle the CPU leaves the array alone
        host_exec = host_req && cpu_idle && ((state == S_IDLE) || (state == S_WAIT));
    end

    // Single write port: CPU and host writes never coincide, host_exec requires an idle CPU
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = cpu_idx;
        mem_wdata = WriteData;
        if (cpu_wr_ok) begin
            mem_we = 1'b1;
        end else if (host_exec && host_we) begin
            mem_we    = 1'b1;
            mem_widx  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Array storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // CPU read data, error flag and write counter; reads see the pre-write word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadData <= 32'd0;
            addr_err <= 1'b0;
            wr_count <= 16'd0;
        end else begin
            if (MemtoRegM) begin
                ReadData <= addr_bad ? 32'd0 : mem[cpu_idx];
            end
            if ((MemWrite || MemtoRegM) && addr_bad) begin
                addr_err <= 1'b1;
            end
            if (cpu_wr_ok && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Host arbiter: wait out CPU activity, execute on the edge into ACK, pulse ack once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            host_ack   <= 1'b0;
            host_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    host_ack <= 1'b0;
                    if (!host_req) begin
                        state <= S_IDLE;
                    end else if (host_exec) begin
                        state    <= S_ACK;
                        host_ack <= 1'b1;
                        if (!host_we) begin
                            host_rdata <= mem[host_addr];
                        end
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_ACK: begin
                    state    <= S_IDLE;
                    host_ack <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    host_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk;
    logic          reset;
    logic          MemWrite;
    logic          MemtoRegM;
    logic [31:0]   ALUResult;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic [31:0]   host_rdata;
    logic          host_ack;
    logic          addr_err;
    logic [15:0]   wr_count;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        mw;
        logic        mr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [15];

    data_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .MemtoRegM  (MemtoRegM),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .addr_err   (addr_err),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic mw, input logic mr, input logic [31:0] addr, input logic [31:0] wd);
        MemWrite  = mw;
        MemtoRegM = mr;
        ALUResult = addr;
        WriteData = wd;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 16'd1};
        vecs[1]  = '{1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h20,  32'hA,        32'hDEADBEEF, 1'b0, 16'd2};
        vecs[4]  = '{1'b1, 1'b1, 32'h20,  32'hB,        32'hA,        1'b0, 16'd3};
        vecs[5]  = '{1'b0, 1'b1, 32'h20,  32'h0,        32'hB,        1'b0, 16'd3};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   32'h77,       32'hB,        1'b0, 16'd4};
        vecs[7]  = '{1'b1, 1'b0, 32'h3FC, 32'h3C,       32'hB,        1'b0, 16'd5};
        vecs[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h0,        32'h3C,       1'b0, 16'd5};
        vecs[9]  = '{1'b1, 1'b0, 32'h13,  32'h5555,     32'h3C,       1'b1, 16'd5};
        vecs[10] = '{1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 16'd5};
        vecs[11] = '{1'b0, 1'b1, 32'h13,  32'h0,        32'h0,        1'b1, 16'd5};
        vecs[12] = '{1'b1, 1'b0, 32'h400, 32'h99,       32'h0,        1'b1, 16'd5};
        vecs[13] = '{1'b0, 1'b1, 32'h0,   32'h0,        32'h77,       1'b1, 16'd5};
        vecs[14] = '{1'b0, 1'b1, 32'h404, 32'h0,        32'h0,        1'b1, 16'd5};

        reset = 1'b0;
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = 32'h0;
        step();
        step();
        chk("reset ReadData",   ReadData,   32'h0);
        chk("reset host_rdata", host_rdata, 32'h0);
        chk("reset host_ack",   {31'h0, host_ack}, 32'h0);
        chk("reset addr_err",   {31'h0, addr_err}, 32'h0);
        chk("reset wr_count",   {16'h0, wr_count}, 32'h0);
        reset = 1'b1;
        step();

        // Table-driven CPU accesses, one cycle each
        for (int i = 0; i < 15; i++) begin
            cpu(vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wd);
            step();
            chk($sformatf("vec%0d ReadData", i), ReadData, vecs[i].rd);
            chk($sformatf("vec%0d addr_err", i), {31'h0, addr_err}, {31'h0, vecs[i].err});
            chk($sformatf("vec%0d wr_count", i), {16'h0, wr_count}, {16'h0, vecs[i].cnt});
        end
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Host write idx 5 while CPU busy for 3 cycles
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 32'h1234;
        cpu(1'b0, 1'b1, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("busy%0d host_ack", i), {31'h0, host_ack}, 32'h0);
        end
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("host wr ack", {31'h0, host_ack}, 32'h1);
        host_req = 1'b0;
        step();
        chk("host wr ack drop", {31'h0, host_ack}, 32'h0);
        cpu(1'b0, 1'b1, 32'h14, 32'h0);
        step();
        chk("cpu reads host word", ReadData, 32'h1234);
        chk("host wr wr_count", {16'h0, wr_count}, 32'd5);
        cpu(1'b0, 1'b0, 32'h0, 32'h0);

        // Host read with CPU idle, then hold of host_rdata
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        step();
        chk("host rd ack", {31'h0, host_ack}, 32'h1);
        chk("host rd data", host_rdata, 32'h1234);
        host_req = 1'b0; host_addr = 8'd4;
        step();
        chk("host rd ack low", {31'h0, host_ack}, 32'h0);
        chk("host rd hold", host_rdata, 32'h1234);

        // Back-to-back requests: no acceptance during ACK
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd4;
        step();
        chk("b2b ack1", {31'h0, host_ack}, 32'h1);
        chk("b2b data1", host_rdata, 32'hDEADBEEF);
        host_addr = 8'd8;
        step();
        chk("b2b gap", {31'h0, host_ack}, 32'h0);
        chk("b2b gap hold", host_rdata, 32'hDEADBEEF);
        step();
        chk("b2b ack2", {31'h0, host_ack}, 32'h1);
        chk("b2b data2", host_rdata, 32'hB);
        host_req = 1'b0;
        step();

        // Request withdrawn while waiting: no access, no ack
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 32'hBAD;
        cpu(1'b0, 1'b1, 32'h10, 32'h0);
        step();
        chk("drop wait ack", {31'h0, host_ack}, 32'h0);
        host_req = 1'b0;
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("drop idle ack", {31'h0, host_ack}, 32'h0);
        step();
        chk("drop late ack", {31'h0, host_ack}, 32'h0);
        cpu(1'b0, 1'b1, 32'h14, 32'h0);
        step();
        chk("drop no write", ReadData, 32'h1234);

        // Address/data changes during WAIT take effect at execution
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd6; host_wdata = 32'h66;
        cpu(1'b1, 1'b0, 32'h24, 32'h24);
        step();
        host_addr = 8'd7;
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("wait change ack", {31'h0, host_ack}, 32'h1);
        host_req = 1'b0;
        cpu(1'b0, 1'b1, 32'h1C, 32'h0);
        step();
        chk("wait change addr", ReadData, 32'h66);
        cpu(1'b0, 1'b1, 32'h24, 32'h0);
        step();
        chk("busy cpu write", ReadData, 32'h24);
        chk("busy wr_count", {16'h0, wr_count}, 32'd6);

        // Reset asserted while in WAIT
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 32'hFFFF;
        cpu(1'b0, 1'b1, 32'h10, 32'h0);
        step();
        chk("pre-reset ack", {31'h0, host_ack}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("async ReadData", ReadData, 32'h0);
        chk("async addr_err", {31'h0, addr_err}, 32'h0);
        chk("async wr_count", {16'h0, wr_count}, 32'h0);
        chk("async host_ack", {31'h0, host_ack}, 32'h0);
        host_req = 1'b0;
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-reset ack%0d", i), {31'h0, host_ack}, 32'h0);
        end
        cpu(1'b0, 1'b1, 32'h14, 32'h0);
        step();
        chk("retain after reset", ReadData, 32'h1234);
        chk("retain addr_err", {31'h0, addr_err}, 32'h0);
        cpu(1'b1, 1'b0, 32'h800, 32'h1);
        step();
        chk("range err", {31'h0, addr_err}, 32'h1);
        chk("range cnt", {16'h0, wr_count}, 32'h0);

        // Counter saturation
        cpu(1'b1, 1'b0, 32'h0, 32'h5);
        repeat (65535) @(posedge clk);
        #1;
        chk("count 65535", {16'h0, wr_count}, 32'hFFFF);
        step();
        chk("count saturate", {16'h0, wr_count}, 32'hFFFF);
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
